// File: rtl/tcp_client_sender.sv
// TCP client sender: opens a connection, streams a counting word pattern in packets.
// Define TCP_CLIENT_AUTOCLOSE_EN to close the session after the final packet.
`timescale 1ns/1ps
module tcp_client_sender #(
    parameter int RETRY_WAIT = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [31:0]  dest_ip,
    input  logic [15:0]  dest_port,
    input  logic [15:0]  xfer_words,
    input  logic [7:0]   pkt_words,
    output logic         m_axis_open_connection_TVALID,
    input  logic         m_axis_open_connection_TREADY,
    output logic [47:0]  m_axis_open_connection_TDATA,
    input  logic         s_axis_open_status_TVALID,
    output logic         s_axis_open_status_TREADY,
    input  logic [23:0]  s_axis_open_status_TDATA,
    output logic         m_axis_tx_metadata_TVALID,
    input  logic         m_axis_tx_metadata_TREADY,
    output logic [31:0]  m_axis_tx_metadata_TDATA,
    input  logic         s_axis_tx_status_TVALID,
    output logic         s_axis_tx_status_TREADY,
    input  logic [63:0]  s_axis_tx_status_TDATA,
    output logic         m_axis_tx_data_TVALID,
    input  logic         m_axis_tx_data_TREADY,
    output logic [511:0] m_axis_tx_data_TDATA,
    output logic [63:0]  m_axis_tx_data_TKEEP,
    output logic         m_axis_tx_data_TLAST,
    output logic         m_axis_close_connection_TVALID,
    input  logic         m_axis_close_connection_TREADY,
    output logic [15:0]  m_axis_close_connection_TDATA,
    output logic         busy,
    output logic         done,
    output logic [1:0]   err_code,
    output logic [15:0]  session_id
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_OPEN,
        S_WAIT_OPEN,
        S_META,
        S_WAIT_STATUS,
        S_DATA,
`ifdef TCP_CLIENT_AUTOCLOSE_EN
        S_CLOSE,
`endif
        S_BACKOFF
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_OPEN = 2'd1;
    localparam logic [1:0] ERR_LOST = 2'd2;

    localparam logic [1:0] ST_OK      = 2'd0;
    localparam logic [1:0] ST_NOSPACE = 2'd2;

    // BACKOFF lasts RETRY_WAIT-1 cycles so metadata reappears RETRY_WAIT cycles after the status beat
    localparam int          WAIT_INIT_I = (RETRY_WAIT > 2) ? RETRY_WAIT - 2 : 0;
    localparam logic [15:0] WAIT_INIT   = 16'(WAIT_INIT_I);

    state_t      r_state;
    logic [31:0] r_ip;
    logic [15:0] r_port;
    logic [15:0] r_remain;
    logic [7:0]  r_pkt_cfg;
    logic [7:0]  r_pkt_size;
    logic [7:0]  r_pkt_left;
    logic [15:0] r_word;
    logic [15:0] r_session;
    logic [1:0]  r_err;
    logic        r_done;
    logic [15:0] r_wait;

    logic [7:0]  w_pkt_first;
    logic [7:0]  w_pkt_next;
    logic [1:0]  w_tx_code;
    logic [31:0] w_word;
    logic        w_unused;

    function automatic logic [7:0] f_pkt_size(
        input logic [15:0] rem,
        input logic [7:0]  pkt
    );
        logic [7:0] p;
        p = (pkt == 8'd0) ? 8'd1 : pkt;
        return (rem < {8'h00, p}) ? rem[7:0] : p;
    endfunction

    always_comb begin
        w_pkt_first = f_pkt_size(r_remain, r_pkt_cfg);
        w_pkt_next  = f_pkt_size(r_remain - 16'd1, r_pkt_cfg);
    end

    assign w_tx_code = s_axis_tx_status_TDATA[63:62];
    assign w_word    = {16'h0000, r_word};

    assign m_axis_open_connection_TVALID = (r_state == S_OPEN);
    assign m_axis_open_connection_TDATA  = {r_port, r_ip};
    assign s_axis_open_status_TREADY     = (r_state == S_WAIT_OPEN);

    assign m_axis_tx_metadata_TVALID = (r_state == S_META);
    assign m_axis_tx_metadata_TDATA  = {2'b00, r_pkt_size, 6'b000000, r_session};
    assign s_axis_tx_status_TREADY   = (r_state == S_WAIT_STATUS);

    assign m_axis_tx_data_TVALID = (r_state == S_DATA);
    assign m_axis_tx_data_TDATA  = {16{w_word}};
    assign m_axis_tx_data_TKEEP  = {64{1'b1}};
    assign m_axis_tx_data_TLAST  = (r_pkt_left == 8'd1);

`ifdef TCP_CLIENT_AUTOCLOSE_EN
    assign m_axis_close_connection_TVALID = (r_state == S_CLOSE);
    assign w_unused = &{1'b0, s_axis_tx_status_TDATA[61:0],
                        s_axis_open_status_TDATA[23:17]};
`else
    assign m_axis_close_connection_TVALID = 1'b0;
    assign w_unused = &{1'b0, s_axis_tx_status_TDATA[61:0],
                        s_axis_open_status_TDATA[23:17],
                        m_axis_close_connection_TREADY};
`endif
    assign m_axis_close_connection_TDATA = r_session;

    assign busy       = (r_state != S_IDLE);
    assign done       = r_done;
    assign err_code   = r_err;
    assign session_id = r_session;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_ip       <= 32'h0;
            r_port     <= 16'h0;
            r_remain   <= 16'h0;
            r_pkt_cfg  <= 8'h0;
            r_pkt_size <= 8'h0;
            r_pkt_left <= 8'h0;
            r_word     <= 16'h0;
            r_session  <= 16'h0;
            r_err      <= ERR_NONE;
            r_done     <= 1'b0;
            r_wait     <= 16'h0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_ip      <= dest_ip;
                        r_port    <= dest_port;
                        r_remain  <= xfer_words;
                        r_pkt_cfg <= pkt_words;
                        r_word    <= 16'h0;
                        r_err     <= ERR_NONE;
                        r_state   <= S_OPEN;
                    end
                end
                S_OPEN: begin
                    if (m_axis_open_connection_TREADY) begin
                        r_state <= S_WAIT_OPEN;
                    end
                end
                S_WAIT_OPEN: begin
                    if (s_axis_open_status_TVALID) begin
                        if (s_axis_open_status_TDATA[16]) begin
                            r_session <= s_axis_open_status_TDATA[15:0];
                            if (r_remain == 16'h0) begin
`ifdef TCP_CLIENT_AUTOCLOSE_EN
                                r_state <= S_CLOSE;
`else
                                r_done  <= 1'b1;
                                r_state <= S_IDLE;
`endif
                            end else begin
                                r_pkt_size <= w_pkt_first;
                                r_pkt_left <= w_pkt_first;
                                r_state    <= S_META;
                            end
                        end else begin
                            r_err   <= ERR_OPEN;
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_META: begin
                    if (m_axis_tx_metadata_TREADY) begin
                        r_state <= S_WAIT_STATUS;
                    end
                end
                S_WAIT_STATUS: begin
                    if (s_axis_tx_status_TVALID) begin
                        if (w_tx_code == ST_OK) begin
                            r_state <= S_DATA;
                        end else if (w_tx_code == ST_NOSPACE) begin
                            r_wait  <= WAIT_INIT;
                            r_state <= (RETRY_WAIT <= 1) ? S_META : S_BACKOFF;
                        end else begin
                            r_err   <= ERR_LOST;
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_BACKOFF: begin
                    if (r_wait == 16'h0) begin
                        r_state <= S_META;
                    end else begin
                        r_wait <= r_wait - 16'd1;
                    end
                end
                S_DATA: begin
                    if (m_axis_tx_data_TREADY) begin
                        r_word     <= r_word + 16'd1;
                        r_remain   <= r_remain - 16'd1;
                        r_pkt_left <= r_pkt_left - 8'd1;
                        if (r_pkt_left == 8'd1) begin
                            if (r_remain == 16'd1) begin
`ifdef TCP_CLIENT_AUTOCLOSE_EN
                                r_state <= S_CLOSE;
`else
                                r_done  <= 1'b1;
                                r_state <= S_IDLE;
`endif
                            end else begin
                                r_pkt_size <= w_pkt_next;
                                r_pkt_left <= w_pkt_next;
                                r_state    <= S_META;
                            end
                        end
                    end
                end
`ifdef TCP_CLIENT_AUTOCLOSE_EN
                S_CLOSE: begin
                    if (m_axis_close_connection_TREADY) begin
                        r_err   <= ERR_NONE;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/tcp_client_sender.md
TCP_CLIENT_SENDER -- requirements
Module: tcp_client_sender

Interface
REQ-001 SHALL have parameter RETRY_WAIT, default 64: idle cycles between a "no space" tx status and the metadata re-send.
REQ-002 SHALL have port clk  in  1: the single clock; all logic is rising-edge.
REQ-003 SHALL have port rst  in  1: reset, synchronous, active-high.
REQ-004 SHALL have start  in  1; dest_ip  in  32; dest_port  in  16; xfer_words  in  16; pkt_words  in  8: pulse to begin a transfer, sampled with start.
REQ-005 SHALL have m_axis_open_connection_TVALID/TREADY/TDATA  out/in/out  1/1/48: {dest_port, dest_ip} with the IP in [31:0].
REQ-006 SHALL have s_axis_open_status_TVALID/TREADY/TDATA  in/out/in  1/1/24: [15:0] session ID, [16] success.
REQ-007 SHALL have m_axis_tx_metadata_TVALID/TREADY/TDATA  out/in/out  1/1/32: [15:0] session, [31:16] byte length.
REQ-008 SHALL have s_axis_tx_status_TVALID/TREADY/TDATA  in/out/in  1/1/64: [63:62] code (0 ok, 1 no connection, 2 no space).
REQ-009 SHALL have m_axis_tx_data_TVALID/TREADY/TDATA/TKEEP/TLAST  out/in/out/out/out  1/1/512/64/1.
REQ-010 SHALL have m_axis_close_connection_TVALID/TREADY/TDATA  out/in/out  1/1/16: session to close.
REQ-011 SHALL have busy  out  1; done  out  1 (one-cycle pulse); err_code  out  2 (0 none, 1 open failed, 2 connection lost); session_id  out  16.

Function
REQ-012 SHALL implement FSM IDLE -> OPEN -> WAIT_OPEN -> META -> WAIT_STATUS -> DATA -> (META | CLOSE) -> IDLE, plus BACKOFF.
REQ-013 IDLE: start accepted only in IDLE; start while busy SHALL be ignored; inputs latched on acceptance; busy high from the next cycle until done.
REQ-014 OPEN: TVALID SHALL assert the cycle after start acceptance and hold with stable TDATA until TREADY.
REQ-015 WAIT_OPEN: s_axis_open_status_TREADY high only here; success=1 latches session_id -> META; success=0 -> err_code=1, done, IDLE.
REQ-016 Packet size SHALL be min(max(pkt_words,1), remaining words); length field = size*64 bytes (16-bit, no overflow since size<=255).
REQ-017 xfer_words=0 SHALL skip META/DATA and go from WAIT_OPEN straight to CLOSE.
REQ-018 META: TVALID held until TREADY; at most one metadata outstanding.
REQ-019 WAIT_STATUS: s_axis_tx_status_TREADY high only here; code 0 -> DATA; 1 -> err_code=2, done, IDLE without close; 2 -> BACKOFF for RETRY_WAIT cycles -> META with identical metadata; 3 treated as 1.
REQ-020 DATA: word n of the transfer (n from 0, across packets) SHALL carry 16 copies of {16'h0, n[15:0]}; TKEEP all ones; TLAST on the packet's final word; n advances only on TVALID&TREADY.
REQ-021 TVALID SHALL stay high throughout DATA (back-to-back words, no bubbles) and TDATA stable under backpressure.
REQ-022 After TLAST handshake: remaining>0 -> META next cycle; remaining=0 -> CLOSE.
REQ-023 CLOSE: close TVALID with session_id held until TREADY, then done pulse, err_code=0, IDLE.
REQ-024 Status/open-status beats arriving outside their wait states SHALL not be accepted (TREADY low).

Reset
REQ-025 rst SHALL return FSM to IDLE in the same edge, aborting any transfer mid-packet without close.
REQ-026 After reset all TVALIDs, all TREADYs, busy, done SHALL be 0; err_code=0; session_id=0; word counters 0.
REQ-027 start coincident with rst SHALL be ignored.

Configuration
REQ-028 Macro TCP_CLIENT_AUTOCLOSE_EN defined: CLOSE state built per REQ-023.
REQ-029 Macro undefined: CLOSE state absent, close TVALID tied 0, done pulses directly after final TLAST (or after open success when xfer_words=0); session left open.

Verification
REQ-030 start, ip=0A010101, port=2888, xfer=4, pkt=2, all ready, status ok -> open TDATA=0B480A010101; meta len=128 twice; words 0..3 with TLAST on 1 and 3; close with opened session; done; err_code=0.
REQ-031 open status success=0 -> no metadata, done pulse, err_code=1, busy drops.
REQ-032 first tx status code 2, RETRY_WAIT=64 -> metadata re-issued exactly 64 cycles after status, same TDATA; then ok -> data proceeds.
REQ-033 xfer=5, pkt=0 -> five 64-byte packets, each single word with TLAST.
REQ-034 tx_data TREADY toggled randomly, xfer=3, pkt=3 -> pattern words 0,1,2 unchanged under stall, single meta len=192.
REQ-035 rst asserted mid-DATA -> all outputs reset next cycle; new start completes normally.
